// File: rtl/i2c_sched_pkg.sv
// Shared types and widths for the I2C request scheduler: FSM state encoding
// and the address/data widths used by the requesters and byte engines.
package i2c_sched_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } sched_state_e;

endpackage

// File: rtl/i2c_req_scheduler_rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_winner+1 with
// wrap-around and returns the first active requester as one-hot plus index.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_winner,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   win_idx
);

  always_comb begin
    logic          found;
    logic [IW-1:0] idx;
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(last_winner) + k) % NREQ);
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        win_idx     = idx;
      end
    end
  end

endmodule

// File: rtl/i2c_req_scheduler.sv
// Shares one I2C transmitter and one receiver engine between NREQ requesters.
// Optional WAIT watchdog enabled by defining I2C_SCHED_TIMEOUT_EN.
module i2c_req_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                     slowclk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_rw,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  input  logic [DATA_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     resp_ack,
  output logic [DATA_W-1:0]        resp_data,
  output logic                     busy,
  output logic                     err,
  output logic                     tx_start,
  output logic [ADDR_W-1:0]        tx_addr,
  output logic [DATA_W-1:0]        tx_data,
  input  logic                     tx_finished,
  input  logic                     tx_ack,
  output logic                     rx_start,
  output logic [ADDR_W-1:0]        rx_addr,
  input  logic                     rx_finished,
  input  logic                     rx_ack,
  input  logic [DATA_W-1:0]        rx_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_e      state_reg, state_next;
  logic [IW-1:0]     last_winner_reg;
  logic [IW-1:0]     win_idx_reg;
  logic [NREQ-1:0]   gnt_reg;
  logic              rw_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              resp_ack_reg;
  logic [DATA_W-1:0] resp_data_reg;

  logic [NREQ-1:0]   arb_onehot;
  logic [IW-1:0]     arb_idx;
  logic              sel_finished;
  logic              sel_ack;
  logic              timeout_hit;

  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [DATA_W-1:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign addr_arr[gi] = req_addr[ADDR_W*gi +: ADDR_W];
    assign data_arr[gi] = req_data[DATA_W*gi +: DATA_W];
  end

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req         (req),
    .last_winner (last_winner_reg),
    .winner      (arb_onehot),
    .win_idx     (arb_idx)
  );

  // Only the engine that was actually started may end the WAIT state.
  assign sel_finished = rw_reg ? rx_finished : tx_finished;
  assign sel_ack      = rw_reg ? rx_ack      : tx_ack;

`ifdef I2C_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] to_cnt_reg;
  logic          to_flag_reg;

  assign timeout_hit = (state_reg == WAIT) && (to_cnt_reg == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge slowclk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_reg  <= '0;
      to_flag_reg <= 1'b0;
    end else begin
      if (state_reg == WAIT && !sel_finished && !timeout_hit)
        to_cnt_reg <= to_cnt_reg + 1'b1;
      else
        to_cnt_reg <= '0;
      // A real finish in the last watchdog cycle still counts as success.
      to_flag_reg <= (state_reg == WAIT) && !sel_finished && timeout_hit;
    end
  end

  assign err = (state_reg == DONE) && to_flag_reg;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign timeout_hit        = 1'b0;
  assign err                = 1'b0;
`endif

  always_ff @(posedge slowclk or negedge rstn) begin
    if (!rstn) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (|req) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT:    if (sel_finished || timeout_hit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt      = '0;
    done     = '0;
    tx_start = 1'b0;
    rx_start = 1'b0;
    busy     = 1'b0;
    case (state_reg)
      LAUNCH: begin
        gnt      = gnt_reg;
        busy     = 1'b1;
        tx_start = !rw_reg;
        rx_start = rw_reg;
      end
      WAIT: begin
        gnt  = gnt_reg;
        busy = 1'b1;
      end
      DONE: begin
        gnt  = gnt_reg;
        busy = 1'b1;
        done = gnt_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge slowclk or negedge rstn) begin
    if (!rstn) begin
      last_winner_reg <= IW'(NREQ - 1);
      win_idx_reg     <= '0;
      gnt_reg         <= '0;
      rw_reg          <= 1'b0;
      addr_reg        <= '0;
      data_reg        <= '0;
      resp_ack_reg    <= 1'b0;
      resp_data_reg   <= '0;
    end else begin
      // Requester inputs are sampled only here, so later changes cannot leak in.
      if (state_reg == IDLE && |req) begin
        win_idx_reg <= arb_idx;
        gnt_reg     <= arb_onehot;
        rw_reg      <= req_rw[arb_idx];
        addr_reg    <= addr_arr[arb_idx];
        data_reg    <= data_arr[arb_idx];
      end
      if (state_reg == WAIT) begin
        if (sel_finished) begin
          resp_ack_reg <= sel_ack;
          if (rw_reg) resp_data_reg <= rx_data;
        end else if (timeout_hit) begin
          resp_ack_reg <= 1'b0;
        end
      end
      if (state_reg == DONE) last_winner_reg <= win_idx_reg;
    end
  end

  assign tx_addr   = addr_reg;
  assign rx_addr   = addr_reg;
  assign tx_data   = data_reg;
  assign resp_ack  = resp_ack_reg;
  assign resp_data = resp_data_reg;

endmodule
